// File: rtl/rv32i_dmem_if_pkg.sv
// rv32i_dmem_if shared definitions: funct3 codes, FSM states,
// and the request decode helpers (BE, store data, access check).
package rv32i_dmem_if_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  function automatic logic acc_err(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic bad_f3;
    logic bad_al;
    if (we)
      bad_f3 = !(f3 == F3_B || f3 == F3_H ||
                 f3 == F3_W);
    else
      bad_f3 = !(f3 == F3_B  || f3 == F3_H  ||
                 f3 == F3_W  || f3 == F3_BU ||
                 f3 == F3_HU);
    bad_al = ((f3[1:0] == 2'b01) && off[0]) ||
             ((f3[1:0] == 2'b10) && (off != 2'b00));
    return bad_f3 || bad_al;
  endfunction

  function automatic logic [3:0] be_of(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic [3:0] be;
    unique case (1'b1)
      f3[1:0] == 2'b00: be = 4'b0001 << off;
      f3[1:0] == 2'b01: be = off[1] ? 4'b1100
                                    : 4'b0011;
      f3[1:0] == 2'b10: be = 4'b1111;
      default:          be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wdata_of(
    input logic [2:0]  f3,
    input logic [31:0] wd
  );
    logic [31:0] d;
    unique case (1'b1)
      f3[1:0] == 2'b00: d = {4{wd[7:0]}};
      f3[1:0] == 2'b01: d = {2{wd[15:0]}};
      default:          d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rv32i_dmem_if_if.sv
// CPU-side request/response bundle and memory-side
// chip-select/acknowledge bus for rv32i_dmem_if.
interface rv32i_dmem_cpu_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_err
  );
endinterface

interface rv32i_dmem_mem_if #(
  parameter int ADDR_W = 32
);
  logic              mem_cs;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_cs, mem_we, mem_be,
    output mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_cs, mem_we, mem_be,
    input  mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/rv32i_load_align.sv
// rv32i_load_align: picks the byte/halfword lane of a
// read word and sign- or zero-extends it per funct3.
module rv32i_load_align
  import rv32i_dmem_if_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [31:0] sh;
  logic [7:0]  b;
  logic [15:0] h;

  // lane select and extension
  always_comb begin
    sh = rdata >> {addr_lo, 3'b000};
    b  = sh[7:0];
    h  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    unique case (1'b1)
      funct3 == F3_B:  data = {{24{b[7]}}, b};
      funct3 == F3_BU: data = {24'd0, b};
      funct3 == F3_H:  data = {{16{h[15]}}, h};
      funct3 == F3_HU: data = {16'd0, h};
      funct3 == F3_W:  data = rdata;
      default:         data = 32'd0;
    endcase
  end

endmodule

// File: rtl/rv32i_dmem_if.sv
// rv32i_dmem_if: one-at-a-time load/store bridge to a
// word RAM. Optional ACCESS timeout: RV32I_DMEM_TIMEOUT_EN.
module rv32i_dmem_if
  import rv32i_dmem_if_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic              clk,
  input logic              reset,
  rv32i_dmem_cpu_if.slave  cpu,
  rv32i_dmem_mem_if.master mem
);

  state_e            state;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic              cs_q;
  logic              mwe_q;
  logic [3:0]        be_q;
  logic [ADDR_W-3:0] addr_q;
  logic [31:0]       wd_q;
  logic              rv_q;
  logic [31:0]       rd_q;
  logic              err_q;
  logic [31:0]       ld_data;
  logic              bad;

`ifdef RV32I_DMEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LAST =
    TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] cnt;
`endif

  assign bad = acc_err(cpu.req_we,
                       cpu.req_funct3,
                       cpu.req_addr[1:0]);

  rv32i_load_align u_align (
    .funct3  (f3_q),
    .addr_lo (off_q),
    .rdata   (mem.mem_rdata),
    .data    (ld_data)
  );

  // request FSM with registered bus/response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      we_q   <= 1'b0;
      f3_q   <= 3'd0;
      off_q  <= 2'd0;
      cs_q   <= 1'b0;
      mwe_q  <= 1'b0;
      be_q   <= 4'd0;
      addr_q <= '0;
      wd_q   <= 32'd0;
      rv_q   <= 1'b0;
      rd_q   <= 32'd0;
      err_q  <= 1'b0;
`ifdef RV32I_DMEM_TIMEOUT_EN
      cnt    <= '0;
`endif
    end else begin
      rv_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cpu.req_valid) begin
            we_q   <= cpu.req_we;
            f3_q   <= cpu.req_funct3;
            off_q  <= cpu.req_addr[1:0];
            addr_q <= cpu.req_addr[ADDR_W-1:2];
            be_q   <= be_of(cpu.req_funct3,
                            cpu.req_addr[1:0]);
            wd_q   <= wdata_of(cpu.req_funct3,
                               cpu.req_wdata);
            if (bad) begin
              state <= S_RESP;
              rv_q  <= 1'b1;
              err_q <= 1'b1;
              rd_q  <= 32'd0;
            end else begin
              state <= S_ACCESS;
              cs_q  <= 1'b1;
              mwe_q <= cpu.req_we;
`ifdef RV32I_DMEM_TIMEOUT_EN
              cnt   <= '0;
`endif
            end
          end
        end
        S_ACCESS: begin
          if (mem.mem_ack) begin
            state <= S_RESP;
            cs_q  <= 1'b0;
            mwe_q <= 1'b0;
            rv_q  <= 1'b1;
            err_q <= 1'b0;
            rd_q  <= we_q ? 32'd0 : ld_data;
          end
`ifdef RV32I_DMEM_TIMEOUT_EN
          else if (cnt == LAST) begin
            state <= S_RESP;
            cs_q  <= 1'b0;
            mwe_q <= 1'b0;
            rv_q  <= 1'b1;
            err_q <= 1'b1;
            rd_q  <= 32'd0;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cpu.req_ready = (state == S_IDLE);
  assign cpu.rsp_valid = rv_q;
  assign cpu.rsp_rdata = rd_q;
  assign cpu.rsp_err   = err_q;
  assign mem.mem_cs    = cs_q;
  assign mem.mem_we    = mwe_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wd_q;

endmodule
